// File: rtl/digit_serial_adder_pkg.sv
// Shared types and constants for the digit-serial adder.
// Optional feature macro: DSA_OVF_EN (adds signed overflow output).
package digit_serial_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int DIGIT_W = 2;

    // Digit counter width: enough for N-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/digit_serial_adder_if.sv
// Request/result bundle between a requester and the digit-serial adder.
// Optional feature macro: DSA_OVF_EN (adds ovf).
interface digit_serial_adder_if #(
    parameter int WIDTH = 8
) ();
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef DSA_OVF_EN
    logic             ovf;
`endif

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout
`ifdef DSA_OVF_EN
        , input ovf
`endif
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout
`ifdef DSA_OVF_EN
        , output ovf
`endif
    );
endinterface

// File: rtl/digit_serial_adder_add2_slice.sv
// Combinational 2-bit ripple adder built from two full-adder cells.
// Optional feature macro: DSA_OVF_EN (exposes carry into the MSB).
module add2_slice
    import digit_serial_pkg::*;
(
    input  logic [DIGIT_W-1:0] x,
    input  logic [DIGIT_W-1:0] y,
    input  logic               cin,
    output logic [DIGIT_W-1:0] z,
    output logic               cout
`ifdef DSA_OVF_EN
    , output logic             c_msb
`endif
);

    logic [DIGIT_W:0] c;

    assign c[0] = cin;

    for (genvar gi = 0; gi < DIGIT_W; gi++) begin : g_fa
        assign z[gi]   = x[gi] ^ y[gi] ^ c[gi];
        assign c[gi+1] = (x[gi] & y[gi]) | (c[gi] & (x[gi] ^ y[gi]));
    end

    assign cout = c[DIGIT_W];

`ifdef DSA_OVF_EN
    assign c_msb = c[DIGIT_W-1];
`endif

endmodule

// File: rtl/digit_serial_adder.sv
// Digit-serial adder: WIDTH-bit a+b+cin, two bits per clock through one 2-bit slice.
// Optional feature macro: DSA_OVF_EN (registered signed overflow output).
module digit_serial_adder
    import digit_serial_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    digit_serial_adder_if.slave  bus
);

    localparam int N  = WIDTH / DIGIT_W;
    localparam int CW = cnt_width(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_sh_q, res_sh_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
`ifdef DSA_OVF_EN
    logic             ovf_q, ovf_d;
    logic             slice_cmsb;
`endif

    logic [DIGIT_W-1:0] slice_z;
    logic               slice_cout;
    logic [WIDTH-1:0]   res_shift;

    add2_slice u_slice (
        .x    (a_sh_q[DIGIT_W-1:0]),
        .y    (b_sh_q[DIGIT_W-1:0]),
        .cin  (carry_q),
        .z    (slice_z),
        .cout (slice_cout)
`ifdef DSA_OVF_EN
        , .c_msb (slice_cmsb)
`endif
    );

    always_comb begin
        // Result digits enter at the top so digit 0 ends at the bottom after N shifts.
        res_shift = res_sh_q >> DIGIT_W;
        res_shift[WIDTH-1 -: DIGIT_W] = slice_z;

        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_sh_d = res_sh_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        sum_d    = sum_q;
        cout_d   = cout_q;
`ifdef DSA_OVF_EN
        ovf_d    = ovf_q;
`endif

        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    a_sh_d   = bus.a;
                    b_sh_d   = bus.b;
                    carry_d  = bus.cin;
                    res_sh_d = '0;
                    cnt_d    = '0;
                    busy_d   = 1'b1;
                    state_d  = RUN;
                end else begin
                    state_d  = IDLE;
                end
            end
            RUN: begin
                a_sh_d   = a_sh_q >> DIGIT_W;
                b_sh_d   = b_sh_q >> DIGIT_W;
                res_sh_d = res_shift;
                carry_d  = slice_cout;
                if (cnt_q == LAST) begin
                    sum_d   = res_shift;
                    cout_d  = slice_cout;
`ifdef DSA_OVF_EN
                    ovf_d   = slice_cmsb ^ slice_cout;
`endif
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_sh_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
`ifdef DSA_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_sh_q <= res_sh_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            sum_q    <= sum_d;
            cout_q   <= cout_d;
`ifdef DSA_OVF_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
`ifdef DSA_OVF_EN
    assign bus.ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_digit_serial_adder.sv
// Self-checking bench for digit_serial_adder at WIDTH=8 and WIDTH=2.
// Optional feature macro: DSA_OVF_EN (also checks ovf).
module tb_digit_serial_adder;

    localparam int N8 = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    digit_serial_adder_if #(.WIDTH(8)) bus8 ();
    digit_serial_adder_if #(.WIDTH(2)) bus2 ();

    digit_serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
    digit_serial_adder #(.WIDTH(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

`ifdef DSA_OVF_EN
    function automatic logic ovf_model(input logic [7:0] a, input logic [7:0] b, input logic cin);
        int s;
        s = int'($signed(a)) + int'($signed(b)) + int'(cin);
        return (s > 127) || (s < -128);
    endfunction
`endif

    // Issues one op on the 8-bit DUT and waits (bounded) for done.
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                        output int lat, output int busy_cyc, output logic [8:0] res,
                        output logic ovf_o, output logic done_after);
        @(negedge clk);
        bus8.start = 1'b1; bus8.a = a; bus8.b = b; bus8.cin = cin;
        @(negedge clk);
        bus8.start = 1'b0;
        bus8.a = 8'($urandom); bus8.b = 8'($urandom); bus8.cin = 1'($urandom);
        lat = 0; busy_cyc = 0;
        while (bus8.done !== 1'b1 && lat < 20) begin
            if (bus8.busy === 1'b1) busy_cyc++;
            @(negedge clk);
            lat++;
        end
        res = {bus8.cout, bus8.sum};
        ovf_o = 1'b0;
`ifdef DSA_OVF_EN
        ovf_o = bus8.ovf;
`endif
        @(negedge clk);
        done_after = bus8.done;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0;
        bus2.start = 1'b0; bus2.a = '0; bus2.b = '0; bus2.cin = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus8.busy, bus8.done, bus8.cout, bus8.sum} !== 11'd0) begin
            errors++;
            $display("FAIL reset8 got busy=%b done=%b cout=%b sum=%h want all 0",
                     bus8.busy, bus8.done, bus8.cout, bus8.sum);
        end
        checks++;
        if ({bus2.busy, bus2.done, bus2.cout, bus2.sum} !== 5'd0) begin
            errors++;
            $display("FAIL reset2 got busy=%b done=%b cout=%b sum=%h want all 0",
                     bus2.busy, bus2.done, bus2.cout, bus2.sum);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (bus8.busy !== 1'b0 || bus8.done !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle got busy=%b done=%b want 0 0", bus8.busy, bus8.done);
        end
        $display("test_reset: done");
    endtask

    task automatic test_basic();
        int lat, bc; logic [8:0] res, expv; logic ov, da;
        logic [7:0] va [2] = '{8'hFF, 8'h5A};
        logic [7:0] vb [2] = '{8'h01, 8'h3C};
        logic       vc [2] = '{1'b0, 1'b1};
        for (int i = 0; i < 27; i++) begin
            logic [7:0] a, b; logic c;
            if (i < 2) begin a = va[i]; b = vb[i]; c = vc[i]; end
            else begin a = 8'($urandom); b = 8'($urandom); c = 1'($urandom); end
            expv = 9'(a) + 9'(b) + 9'(c);
            run8(a, b, c, lat, bc, res, ov, da);
            $display("op %h + %h + %b -> %h (latency %0d)", a, b, c, res, lat);
            checks++;
            if (res !== expv) begin
                errors++; $display("FAIL sum8 %h+%h+%b got %h want %h", a, b, c, res, expv);
            end
            checks++;
            if (lat !== N8) begin
                errors++; $display("FAIL latency8 got %0d want %0d", lat, N8);
            end
            checks++;
            if (bc !== N8) begin
                errors++; $display("FAIL busy_cycles8 got %0d want %0d", bc, N8);
            end
            checks++;
            if (da !== 1'b0) begin
                errors++; $display("FAIL done_pulse8 got done=%b after pulse want 0", da);
            end
`ifdef DSA_OVF_EN
            checks++;
            if (ov !== ovf_model(a, b, c)) begin
                errors++; $display("FAIL ovf8 %h+%h+%b got %b want %b", a, b, c, ov, ovf_model(a, b, c));
            end
`endif
            if (i == 1) begin
                repeat (3) @(negedge clk);
                checks++;
                if ({bus8.cout, bus8.sum} !== expv) begin
                    errors++; $display("FAIL hold8 got %h want %h", {bus8.cout, bus8.sum}, expv);
                end
            end
        end
    endtask

    task automatic test_start_ignored();
        int ndone = 0; logic [8:0] res = '0;
        @(negedge clk);
        bus8.start = 1'b1; bus8.a = 8'h01; bus8.b = 8'h02; bus8.cin = 1'b0;
        @(negedge clk);
        bus8.a = 8'h11; bus8.b = 8'h22;
        @(negedge clk);
        bus8.start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (bus8.done === 1'b1) begin ndone++; res = {bus8.cout, bus8.sum}; end
            @(negedge clk);
        end
        $display("start_ignored: dones=%0d result=%h", ndone, res);
        checks++;
        if (ndone !== 1) begin
            errors++; $display("FAIL ignored_done_count got %0d want 1", ndone);
        end
        checks++;
        if (res !== 9'h003) begin
            errors++; $display("FAIL ignored_result got %h want 003", res);
        end
        checks++;
        if (bus8.busy !== 1'b0) begin
            errors++; $display("FAIL ignored_busy got %b want 0", bus8.busy);
        end
    endtask

    task automatic test_reset_mid_run();
        int lat, bc; logic [8:0] res; logic ov, da;
        @(negedge clk);
        bus8.start = 1'b1; bus8.a = 8'h55; bus8.b = 8'h66; bus8.cin = 1'b1;
        @(negedge clk);
        bus8.start = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (bus8.busy !== 1'b1) begin
            errors++; $display("FAIL midrun_busy got %b want 1", bus8.busy);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus8.busy, bus8.done, bus8.cout, bus8.sum} !== 11'd0) begin
            errors++;
            $display("FAIL midrun_reset got busy=%b done=%b cout=%b sum=%h want all 0",
                     bus8.busy, bus8.done, bus8.cout, bus8.sum);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run8(8'h10, 8'h20, 1'b0, lat, bc, res, ov, da);
        $display("after reset: 10 + 20 -> %h (latency %0d)", res, lat);
        checks++;
        if (res !== 9'h030 || lat !== N8) begin
            errors++; $display("FAIL post_reset_op got %h lat %0d want 030 lat %0d", res, lat, N8);
        end
    endtask

    task automatic test_back_to_back();
        int lat = 0, gap = 0; logic [8:0] r1, r2;
        @(negedge clk);
        bus8.start = 1'b1; bus8.a = 8'h12; bus8.b = 8'h34; bus8.cin = 1'b0;
        @(negedge clk);
        bus8.a = 8'h80; bus8.b = 8'h80;
        while (bus8.done !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end
        r1 = {bus8.cout, bus8.sum};
        do begin
            @(negedge clk);
            gap++;
            if (gap == 1) bus8.start = 1'b0;
        end while (bus8.done !== 1'b1 && gap < 20);
        r2 = {bus8.cout, bus8.sum};
        $display("back_to_back: first %h lat %0d, second %h gap %0d", r1, lat, r2, gap);
        checks++;
        if (r1 !== 9'h046 || lat !== N8) begin
            errors++; $display("FAIL b2b_first got %h lat %0d want 046 lat %0d", r1, lat, N8);
        end
        checks++;
        if (r2 !== 9'h100) begin
            errors++; $display("FAIL b2b_second got %h want 100", r2);
        end
        checks++;
        if (gap !== N8 + 1) begin
            errors++; $display("FAIL b2b_gap got %0d want %0d", gap, N8 + 1);
        end
        @(negedge clk);
        checks++;
        if (bus8.done !== 1'b0) begin
            errors++; $display("FAIL b2b_done_drop got %b want 0", bus8.done);
        end
    endtask

    task automatic test_width2_exhaustive();
        for (int a = 0; a < 4; a++) begin
            for (int b = 0; b < 4; b++) begin
                for (int c = 0; c < 2; c++) begin
                    int lat = 0; logic [2:0] res, expv;
                    expv = 3'(a + b + c);
                    @(negedge clk);
                    bus2.start = 1'b1; bus2.a = 2'(a); bus2.b = 2'(b); bus2.cin = 1'(c);
                    @(negedge clk);
                    bus2.start = 1'b0;
                    while (bus2.done !== 1'b1 && lat < 10) begin @(negedge clk); lat++; end
                    res = {bus2.cout, bus2.sum};
                    $display("w2 %0d + %0d + %0d -> %0d (latency %0d)", a, b, c, res, lat);
                    checks++;
                    if (res !== expv || lat !== 1) begin
                        errors++;
                        $display("FAIL w2 %0d+%0d+%0d got %0d lat %0d want %0d lat 1", a, b, c, res, lat, expv);
                    end
                end
            end
        end
    endtask

`ifdef DSA_OVF_EN
    task automatic test_ovf();
        int lat, bc; logic [8:0] res; logic ov, da;
        run8(8'h7F, 8'h01, 1'b0, lat, bc, res, ov, da);
        $display("ovf: 7F + 01 -> %h ovf=%b", res, ov);
        checks++;
        if (ov !== 1'b1) begin
            errors++; $display("FAIL ovf_7f got %b want 1", ov);
        end
        run8(8'hFF, 8'h01, 1'b0, lat, bc, res, ov, da);
        $display("ovf: FF + 01 -> %h ovf=%b", res, ov);
        checks++;
        if (ov !== 1'b0) begin
            errors++; $display("FAIL ovf_ff got %b want 0", ov);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_start_ignored();
        test_reset_mid_run();
        test_back_to_back();
        test_width2_exhaustive();
`ifdef DSA_OVF_EN
        test_ovf();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
